// File: rtl/syn_sweep_ctrl.sv
// ============================================================================
// Module   : syn_sweep_ctrl
// Purpose  : Sweeps the synaptic (and optional gradient) SRAM row belonging to
//            one pre-neuron, either read-only or read-modify-write.
// Options  : define SYN_GRAD_ACCUM_EN to mirror SRAM strobes onto the
//            gradient array during train sweeps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module syn_sweep_ctrl #(
  parameter int INPUT_NEURON         = 784,
  parameter int OUTPUT_NEURON        = 256,
  parameter int POST_NEUR_PARALLEL   = 4,
  parameter int PRE_NEUR_ADDR_WIDTH  = 10,
  parameter int POST_NEUR_ADDR_WIDTH = 10,
  parameter int SYN_ARRAY_ADDR_WIDTH = 16
) (
  input  logic                            CLK,
  input  logic                            RST_N,
  input  logic                            START,
  input  logic [PRE_NEUR_ADDR_WIDTH-1:0]  PRE_ADDR,
  input  logic                            IS_TRAIN,
  output logic                            BUSY,
  output logic                            DONE,
  output logic                            ERR,
  output logic                            RDATA_VALID,
  output logic                            CTRL_SYNARRAY_CS,
  output logic                            CTRL_SYNARRAY_WE,
  output logic [SYN_ARRAY_ADDR_WIDTH-1:0] CTRL_SYNARRAY_ADDR,
  output logic                            CTRL_GRAD_ARRAY_CS,
  output logic                            CTRL_GRAD_ARRAY_WE,
  output logic [POST_NEUR_ADDR_WIDTH-1:0] CTRL_POST_NEURON_ADDRESS,
  output logic                            CTRL_TREF_EVENT
);

  localparam int              c_words   = OUTPUT_NEURON / POST_NEUR_PARALLEL;
  localparam int              c_kw      = (c_words > 1) ? $clog2(c_words) : 1;
  localparam logic [c_kw-1:0] c_k_last  = c_kw'(c_words - 1);
  localparam logic [31:0]     c_words32 = 32'(c_words);
  localparam logic [31:0]     c_in32    = 32'(INPUT_NEURON);
  localparam logic [31:0]     c_par32   = 32'(POST_NEUR_PARALLEL);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t                          state_q;
  logic [c_kw-1:0]                 k_q;
  logic [SYN_ARRAY_ADDR_WIDTH-1:0] base_q;
  logic                            train_q;
  logic                            done_q;
  logic                            err_q;
  logic                            rvalid_q;
  logic                            cs_q;
  logic                            we_q;
  logic                            tref_q;
  logic [SYN_ARRAY_ADDR_WIDTH-1:0] addr_q;
  logic [POST_NEUR_ADDR_WIDTH-1:0] post_q;

  logic                            start_ok_d;
  logic [SYN_ARRAY_ADDR_WIDTH-1:0] base_d;
  logic [c_kw-1:0]                 k_d;
  logic [SYN_ARRAY_ADDR_WIDTH-1:0] addr_d;
  logic [POST_NEUR_ADDR_WIDTH-1:0] post_d;

  assign start_ok_d = (32'(PRE_ADDR) < c_in32);
  assign base_d     = SYN_ARRAY_ADDR_WIDTH'(32'(PRE_ADDR) * c_words32);
  // k_d is only consumed when k_q is below the last word, so it never wraps.
  assign k_d        = k_q + 1'b1;
  assign addr_d     = base_q + SYN_ARRAY_ADDR_WIDTH'(k_d);
  assign post_d     = POST_NEUR_ADDR_WIDTH'(32'(k_d) * c_par32);

  // Outputs are registered together with the state so they describe the state entered.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      base_q   <= '0;
      train_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      cs_q     <= 1'b0;
      we_q     <= 1'b0;
      tref_q   <= 1'b0;
      addr_q   <= '0;
      post_q   <= '0;
    end else begin
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rvalid_q <= (state_q == ST_READ) && !train_q;
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            if (start_ok_d) begin
              state_q <= ST_READ;
              base_q  <= base_d;
              train_q <= IS_TRAIN;
              k_q     <= '0;
              cs_q    <= 1'b1;
              we_q    <= 1'b0;
              tref_q  <= 1'b0;
              addr_q  <= base_d;
              post_q  <= '0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (train_q) begin
            state_q <= ST_WRITE;
            we_q    <= 1'b1;
            tref_q  <= 1'b1;
          end else if (k_q == c_k_last) begin
            state_q <= ST_DRAIN;
            cs_q    <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            k_q    <= k_d;
            addr_q <= addr_d;
            post_q <= post_d;
          end
        end
        ST_WRITE: begin
          we_q   <= 1'b0;
          tref_q <= 1'b0;
          if (k_q == c_k_last) begin
            state_q <= ST_DRAIN;
            cs_q    <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_READ;
            k_q     <= k_d;
            addr_q  <= addr_d;
            post_q  <= post_d;
          end
        end
        ST_DRAIN: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          cs_q    <= 1'b0;
          we_q    <= 1'b0;
          tref_q  <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY                     = (state_q != ST_IDLE);
  assign DONE                     = done_q;
  assign ERR                      = err_q;
  assign RDATA_VALID              = rvalid_q;
  assign CTRL_SYNARRAY_CS         = cs_q;
  assign CTRL_SYNARRAY_WE         = we_q;
  assign CTRL_SYNARRAY_ADDR       = addr_q;
  assign CTRL_POST_NEURON_ADDRESS = post_q;
  assign CTRL_TREF_EVENT          = tref_q;

`ifdef SYN_GRAD_ACCUM_EN
  assign CTRL_GRAD_ARRAY_CS = cs_q & train_q;
  assign CTRL_GRAD_ARRAY_WE = we_q & train_q;
`else
  assign CTRL_GRAD_ARRAY_CS = 1'b0;
  assign CTRL_GRAD_ARRAY_WE = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_syn_sweep_ctrl.sv
// ============================================================================
// Module   : tb_syn_sweep_ctrl
// Purpose  : Directed self-checking bench for syn_sweep_ctrl (default params).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_syn_sweep_ctrl;

  localparam int c_words = 64;

  logic        CLK;
  logic        RST_N;
  logic        START;
  logic [9:0]  PRE_ADDR;
  logic        IS_TRAIN;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic        RDATA_VALID;
  logic        CS;
  logic        WE;
  logic [15:0] ADDR;
  logic        GCS;
  logic        GWE;
  logic [9:0]  POST;
  logic        TREF;

  int n_cmp = 0;
  int n_bad = 0;

  syn_sweep_ctrl u_dut (
    .CLK                      (CLK),
    .RST_N                    (RST_N),
    .START                    (START),
    .PRE_ADDR                 (PRE_ADDR),
    .IS_TRAIN                 (IS_TRAIN),
    .BUSY                     (BUSY),
    .DONE                     (DONE),
    .ERR                      (ERR),
    .RDATA_VALID              (RDATA_VALID),
    .CTRL_SYNARRAY_CS         (CS),
    .CTRL_SYNARRAY_WE         (WE),
    .CTRL_SYNARRAY_ADDR       (ADDR),
    .CTRL_GRAD_ARRAY_CS       (GCS),
    .CTRL_GRAD_ARRAY_WE       (GWE),
    .CTRL_POST_NEURON_ADDRESS (POST),
    .CTRL_TREF_EVENT          (TREF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic any_out();
    return |{BUSY, DONE, ERR, RDATA_VALID, CS, WE, ADDR, GCS, GWE, POST, TREF};
  endfunction

  // Drives one sweep from cycle 0 and checks every cycle against a cycle-indexed model.
  task automatic run_sweep(input string tag, input int pre, input bit train, input int collide_at);
    int base, last, k, seq_err, we_cnt, tref_cnt, rd_cnt, done_cnt, done_cyc, rv_cnt, first_addr;
    bit acc, wr, e_gcs, e_gwe;
    base = pre * c_words;
    last = train ? (2 * c_words + 1) : (c_words + 1);
    seq_err = 0; we_cnt = 0; tref_cnt = 0; rd_cnt = 0;
    done_cnt = 0; done_cyc = -1; rv_cnt = 0; first_addr = -1;
    START = 1'b1; PRE_ADDR = 10'(pre); IS_TRAIN = train;
    step();
    START = 1'b0;
    for (int c = 1; c <= last + 2; c++) begin
      acc = (c < last);
      k   = train ? (c - 1) / 2 : c - 1;
      wr  = train && acc && (c % 2 == 0);
`ifdef SYN_GRAD_ACCUM_EN
      e_gcs = train && acc;
      e_gwe = wr;
`else
      e_gcs = 1'b0;
      e_gwe = 1'b0;
`endif
      if (CS !== acc || WE !== wr || TREF !== wr || BUSY !== (c <= last) ||
          DONE !== (c == last) || ERR !== 1'b0 || GCS !== e_gcs || GWE !== e_gwe ||
          RDATA_VALID !== (!train && c >= 2 && c <= last))
        seq_err++;
      if (acc && (ADDR !== 16'(base + k) || POST !== 10'(k * 4)))
        seq_err++;
      if (c == 1) first_addr = int'(ADDR);
      if (WE === 1'b1) we_cnt++;
      if (TREF === 1'b1) tref_cnt++;
      if (CS === 1'b1 && WE === 1'b0) rd_cnt++;
      if (RDATA_VALID === 1'b1) rv_cnt++;
      if (DONE === 1'b1) begin
        done_cnt++;
        done_cyc = c;
      end
      if (c == 2 * c_words - 1 && train) begin
        check({tag, "_last_addr"}, 32'(ADDR), 32'(base + c_words - 1));
        check({tag, "_last_post"}, 32'(POST), 32'(4 * (c_words - 1)));
      end
      if (c == collide_at) begin
        START = 1'b1; PRE_ADDR = 10'd10; IS_TRAIN = 1'b0;
      end
      if (c == collide_at + 1) START = 1'b0;
      step();
    end
    check({tag, "_seq_errs"}, 32'(seq_err), 32'd0);
    check({tag, "_first_addr"}, 32'(first_addr), 32'(base));
    check({tag, "_we_cnt"}, 32'(we_cnt), train ? 32'd64 : 32'd0);
    check({tag, "_tref_cnt"}, 32'(tref_cnt), train ? 32'd64 : 32'd0);
    check({tag, "_rd_cnt"}, 32'(rd_cnt), 32'd64);
    check({tag, "_rv_cnt"}, 32'(rv_cnt), train ? 32'd0 : 32'd64);
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_done_cyc"}, 32'(done_cyc), train ? 32'd129 : 32'd65);
  endtask

  initial begin
    int cs_seen;
    RST_N = 1'b0; START = 1'b0; PRE_ADDR = '0; IS_TRAIN = 1'b0;
    #2;
    check("reset_outputs", 32'(any_out()), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    step();

    // Train sweep with a colliding START at cycle 10.
    run_sweep("train3", 3, 1'b1, 10);

    // Out-of-range pre-neuron.
    START = 1'b1; PRE_ADDR = 10'd784; IS_TRAIN = 1'b1;
    step();
    START = 1'b0;
    check("bad_err_pulse", 32'(ERR), 32'd1);
    check("bad_busy", 32'(BUSY), 32'd0);
    cs_seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (CS === 1'b1 || BUSY === 1'b1) cs_seen++;
      step();
    end
    check("bad_err_clear", 32'(ERR), 32'd0);
    check("bad_no_access", 32'(cs_seen), 32'd0);

    // Reset asserted while writing.
    START = 1'b1; PRE_ADDR = 10'd0; IS_TRAIN = 1'b1;
    step();
    START = 1'b0;
    for (int c = 1; c < 40; c++) step();
    check("rst_pre_we", 32'(WE), 32'd1);
    RST_N = 1'b0;
    #1;
    check("rst_async_outputs", 32'(any_out()), 32'd0);
    step();
    step();
    check("rst_held_outputs", 32'(any_out()), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    step();
    check("rst_idle_busy", 32'(BUSY), 32'd0);
    check("rst_idle_we", 32'(WE), 32'd0);

    // Read-only sweep on the last valid pre-neuron.
    run_sweep("ro783", 783, 1'b0, -5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
